// File: rtl/fifo_rd_ctrl_pkg.sv
// Shared definitions for the async FIFO read-side controller: default sizes
// and the Gray/binary pointer conversions, also used by the write-side controller.
// No ports; pure package. Conversions are width-generic via zero-extension to 32 bits.
package fifo_rd_ctrl_pkg;

  localparam int DEF_ADDR_WIDTH    = 4;
  localparam int DEF_DATA_WIDTH    = 8;
  localparam int DEF_AEMPTY_THRESH = 2;

  // Zero-extending a narrower pointer to 32 bits leaves both conversions
  // unchanged in the low bits, so callers just cast back to their width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// Read-side bus bundle: memory read port (raddr/ren/rdata_mem) and the
// show-ahead output stream (dout/dout_valid/dout_ready).
// master = controller side, slave = memory + consumer side.
interface fifo_rd_ctrl_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] raddr;
  logic                  ren;
  logic [DATA_WIDTH-1:0] rdata_mem;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_valid;
  logic                  dout_ready;

  modport master (
    output raddr, ren, dout, dout_valid,
    input  rdata_mem, dout_ready
  );

  modport slave (
    input  raddr, ren, dout, dout_valid,
    output rdata_mem, dout_ready
  );
endinterface

// File: rtl/fifo_rd_ctrl_sync_w2r.sv
// sync_w2r: 2-flop synchronizer of the Gray write pointer into r_clk.
// Latency: 2 r_clk edges. No backpressure (free-running).
// Ports: r_clk, r_rstn (async active-low), wptr (async Gray in), rq2_wptr (synced out).
module sync_w2r #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                r_clk,
  input  logic                r_rstn,
  input  logic [ADDR_WIDTH:0] wptr,
  output logic [ADDR_WIDTH:0] rq2_wptr
);

  logic [ADDR_WIDTH:0] rq1_q, rq1_d;
  logic [ADDR_WIDTH:0] rq2_q, rq2_d;

  always_comb begin
    rq1_d = wptr;
    rq2_d = rq1_q;
  end

  always_ff @(posedge r_clk or negedge r_rstn) begin
    if (!r_rstn) begin
      rq1_q <= '0;
      rq2_q <= '0;
    end else begin
      rq1_q <= rq1_d;
      rq2_q <= rq2_d;
    end
  end

  assign rq2_wptr = rq2_q;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the async FIFO: synced write pointer, read pointer, flags, show-ahead output.
// Latency: wptr change -> dout_valid after 5 r_clk edges when idle; 1 word/cycle sustained.
// Backpressure: dout held while !dout_ready; 2-entry buffer + 1 in-flight read, ren throttled to fit.
// Ports: r_clk/r_rstn, wptr in (Gray, async), rptr out (Gray, registered), r_empty/r_aempty/r_level
//        flags, rd_if (master): memory raddr/ren/rdata_mem and dout/dout_valid/dout_ready stream.
module fifo_rd_ctrl
  import fifo_rd_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int AEMPTY_THRESH = DEF_AEMPTY_THRESH
) (
  input  logic                r_clk,
  input  logic                r_rstn,
  input  logic [ADDR_WIDTH:0] wptr,
  output logic [ADDR_WIDTH:0] rptr,
  output logic                r_empty,
  output logic                r_aempty,
  output logic [ADDR_WIDTH:0] r_level,
  fifo_rd_ctrl_if.master      rd_if
);

  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] AE_TH = PTR_W'(AEMPTY_THRESH);

  logic [ADDR_WIDTH:0]   rq2_wptr;
  logic [ADDR_WIDTH:0]   wbin_sync;

  logic [ADDR_WIDTH:0]   rbin_q, rbin_d;
  logic [ADDR_WIDTH:0]   rptr_q, rptr_d;
  logic                  r_empty_q, r_empty_d;

  // Output stage: head is what the consumer sees, skid catches a word that
  // arrives while the head is held; infl marks a memory read in flight.
  logic [DATA_WIDTH-1:0] head_dat_q, head_dat_d;
  logic                  head_vld_q, head_vld_d;
  logic [DATA_WIDTH-1:0] skid_dat_q, skid_dat_d;
  logic                  skid_vld_q, skid_vld_d;
  logic                  infl_q, infl_d;

  logic                  pop;
  logic [1:0]            occ;
  logic                  ren;

  sync_w2r #(.ADDR_WIDTH(ADDR_WIDTH)) u_sync_w2r (
    .r_clk    (r_clk),
    .r_rstn   (r_rstn),
    .wptr     (wptr),
    .rq2_wptr (rq2_wptr)
  );

  always_comb begin
    wbin_sync = PTR_W'(gray2bin(32'(rq2_wptr)));
    r_level   = wbin_sync - rbin_q;
    r_aempty  = (r_level <= AE_TH);
  end

  always_comb begin
    pop = head_vld_q && rd_if.dout_ready;
    occ = {1'b0, head_vld_q} + {1'b0, skid_vld_q} + {1'b0, infl_q};
    // Issue a read only if, after this cycle's pop, the word it returns
    // still has a slot: keeps at most 2 words outside memory.
    ren = !r_empty_q && ((occ - {1'b0, pop}) < 2'd2);

    rbin_d    = rbin_q + {{ADDR_WIDTH{1'b0}}, ren};
    rptr_d    = PTR_W'(bin2gray(32'(rbin_d)));
    // Compare against the post-increment pointer so r_empty already accounts
    // for the read issued this cycle.
    r_empty_d = (rptr_d == rq2_wptr);
    infl_d    = ren;

    head_dat_d = head_dat_q;
    head_vld_d = head_vld_q;
    skid_dat_d = skid_dat_q;
    skid_vld_d = skid_vld_q;

    // With occ <= 2, skid valid implies no read in flight, so the skid->head
    // move and an arrival never compete for the same slot.
    if (pop) begin
      if (skid_vld_q) begin
        head_dat_d = skid_dat_q;
        head_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else if (infl_q) begin
        head_dat_d = rd_if.rdata_mem;
        head_vld_d = 1'b1;
      end else begin
        head_vld_d = 1'b0;
      end
    end else if (infl_q) begin
      if (!head_vld_q) begin
        head_dat_d = rd_if.rdata_mem;
        head_vld_d = 1'b1;
      end else begin
        skid_dat_d = rd_if.rdata_mem;
        skid_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge r_clk or negedge r_rstn) begin
    if (!r_rstn) begin
      rbin_q     <= '0;
      rptr_q     <= '0;
      r_empty_q  <= 1'b1;
      head_dat_q <= '0;
      head_vld_q <= 1'b0;
      skid_dat_q <= '0;
      skid_vld_q <= 1'b0;
      infl_q     <= 1'b0;
    end else begin
      rbin_q     <= rbin_d;
      rptr_q     <= rptr_d;
      r_empty_q  <= r_empty_d;
      head_dat_q <= head_dat_d;
      head_vld_q <= head_vld_d;
      skid_dat_q <= skid_dat_d;
      skid_vld_q <= skid_vld_d;
      infl_q     <= infl_d;
    end
  end

  assign rptr             = rptr_q;
  assign r_empty          = r_empty_q;
  assign rd_if.raddr      = rbin_q[ADDR_WIDTH-1:0];
  assign rd_if.ren        = ren;
  assign rd_if.dout       = head_dat_q;
  assign rd_if.dout_valid = head_vld_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
module tb_fifo_rd_ctrl;

  logic       r_clk = 1'b0;
  logic       r_rstn;
  logic [4:0] wptr;
  logic [4:0] rptr;
  logic       r_empty;
  logic       r_aempty;
  logic [4:0] r_level;

  fifo_rd_ctrl_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) bus ();

  fifo_rd_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .AEMPTY_THRESH(2)) dut (
    .r_clk    (r_clk),
    .r_rstn   (r_rstn),
    .wptr     (wptr),
    .rptr     (rptr),
    .r_empty  (r_empty),
    .r_aempty (r_aempty),
    .r_level  (r_level),
    .rd_if    (bus)
  );

  always #5 r_clk = ~r_clk;

  logic [7:0] mem [16];
  logic [7:0] exp_q [$];
  logic [4:0] wbin;
  int         n_checks;
  int         n_pass;

  // wptr history as seen at r_clk edges: w_h0 ~ rq1, w_h1 ~ rq2, w_h2 ~ previous rq2.
  logic [4:0] w_h0, w_h1, w_h2;
  always @(posedge r_clk or negedge r_rstn) begin
    if (!r_rstn) begin
      w_h0 <= '0; w_h1 <= '0; w_h2 <= '0;
    end else begin
      w_h0 <= wptr; w_h1 <= w_h0; w_h2 <= w_h1;
    end
  end

  // Memory model: one-cycle registered read.
  always @(posedge r_clk) begin
    if (bus.ren) bus.rdata_mem <= mem[bus.raddr];
  end

  function automatic logic [4:0] g2b(input logic [4:0] g);
    logic [4:0] b;
    b[4] = g[4];
    for (int i = 3; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [4:0] b2g(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge r_clk);
    #1;
  endtask

  task automatic write_word();
    logic [7:0] d;
    d = 8'($urandom_range(0, 255));
    mem[wbin[3:0]] = d;
    exp_q.push_back(d);
    wbin = wbin + 5'd1;
    wptr = b2g(wbin);
  endtask

  task automatic do_reset();
    r_rstn = 1'b0;
    wptr = '0;
    wbin = '0;
    bus.dout_ready = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge r_clk);
    #1;
    r_rstn = 1'b1;
  endtask

  task automatic test_reset();
    r_rstn = 1'b0;
    wptr = '0;
    wbin = '0;
    bus.dout_ready = 1'b0;
    repeat (3) @(posedge r_clk);
    @(negedge r_clk);
    n_checks++; if (r_empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", r_empty); else n_pass++;
    n_checks++; if (r_aempty !== 1'b1) $display("FAIL reset_aempty: got %b want 1", r_aempty); else n_pass++;
    n_checks++; if (bus.dout_valid !== 1'b0) $display("FAIL reset_dout_valid: got %b want 0", bus.dout_valid); else n_pass++;
    n_checks++; if (rptr !== 5'd0) $display("FAIL reset_rptr: got %h want 0", rptr); else n_pass++;
    n_checks++; if (bus.raddr !== 4'd0) $display("FAIL reset_raddr: got %h want 0", bus.raddr); else n_pass++;
    n_checks++; if (bus.ren !== 1'b0) $display("FAIL reset_ren: got %b want 0", bus.ren); else n_pass++;
    n_checks++; if (r_level !== 5'd0) $display("FAIL reset_level: got %0d want 0", r_level); else n_pass++;
    n_checks++; if (bus.dout !== 8'd0) $display("FAIL reset_dout: got %h want 0", bus.dout); else n_pass++;
    tick();
    r_rstn = 1'b1;
  endtask

  task automatic test_single();
    int ren_cnt, ren_at, vld_at;
    logic [3:0] ren_addr;
    logic empty3, empty4, stable;
    do_reset();
    tick();
    write_word();
    ren_cnt = 0; ren_at = -1; vld_at = -1; ren_addr = 4'hf; empty3 = 1'bx; empty4 = 1'bx;
    for (int k = 1; k <= 8; k++) begin
      tick();
      @(negedge r_clk);
      if (bus.ren) begin ren_cnt++; ren_at = k; ren_addr = bus.raddr; end
      if (bus.dout_valid && vld_at < 0) vld_at = k;
      if (k == 3) empty3 = r_empty;
      if (k == 4) empty4 = r_empty;
    end
    n_checks++; if (ren_cnt !== 1) $display("FAIL single_ren_count: got %0d want 1", ren_cnt); else n_pass++;
    n_checks++; if (ren_at !== 3) $display("FAIL single_ren_edge: got E%0d want E3", ren_at); else n_pass++;
    n_checks++; if (ren_addr !== 4'd0) $display("FAIL single_raddr: got %0d want 0", ren_addr); else n_pass++;
    n_checks++; if (vld_at !== 5) $display("FAIL single_valid_edge: got E%0d want E5", vld_at); else n_pass++;
    n_checks++; if (empty3 !== 1'b0) $display("FAIL single_empty_E3: got %b want 0", empty3); else n_pass++;
    n_checks++; if (empty4 !== 1'b1) $display("FAIL single_empty_E4: got %b want 1", empty4); else n_pass++;
    n_checks++; if (rptr !== 5'b00001) $display("FAIL single_rptr: got %b want 00001", rptr); else n_pass++;
    n_checks++; if (bus.dout !== exp_q[0]) $display("FAIL single_dout: got %h want %h", bus.dout, exp_q[0]); else n_pass++;
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      @(negedge r_clk);
      if (!(bus.dout_valid === 1'b1 && bus.dout === exp_q[0] && bus.ren === 1'b0)) stable = 1'b0;
    end
    n_checks++; if (stable !== 1'b1) $display("FAIL single_hold: got stable=%b want 1", stable); else n_pass++;
    tick();
    bus.dout_ready = 1'b1;
    @(negedge r_clk);
    n_checks++; if (bus.dout !== exp_q[0]) $display("FAIL single_pop_data: got %h want %h", bus.dout, exp_q[0]); else n_pass++;
    void'(exp_q.pop_front());
    tick();
    bus.dout_ready = 1'b0;
    @(negedge r_clk);
    n_checks++; if (bus.dout_valid !== 1'b0) $display("FAIL single_after_pop_valid: got %b want 0", bus.dout_valid); else n_pass++;
  endtask

  task automatic test_burst();
    int pops, bubbles, lvl_bad, cyc;
    logic started;
    logic [4:0] lvl;
    do_reset();
    tick();
    repeat (16) write_word();
    bus.dout_ready = 1'b1;
    tick();
    tick();
    @(negedge r_clk);
    n_checks++; if (r_level !== 5'd16) $display("FAIL burst_level16: got %0d want 16", r_level); else n_pass++;
    n_checks++; if (r_aempty !== 1'b0) $display("FAIL burst_aempty_full: got %b want 0", r_aempty); else n_pass++;
    pops = 0; bubbles = 0; lvl_bad = 0; cyc = 0; started = 1'b0;
    while (pops < 16 && cyc < 100) begin
      lvl = g2b(w_h1) - g2b(rptr);
      if (r_level !== lvl || r_aempty !== (lvl <= 5'd2)) lvl_bad++;
      if (bus.dout_valid) begin
        n_checks++;
        if (bus.dout !== exp_q[0]) $display("FAIL burst_data[%0d]: got %h want %h", pops, bus.dout, exp_q[0]);
        else n_pass++;
        void'(exp_q.pop_front());
        pops++;
        started = 1'b1;
      end else if (started) begin
        bubbles++;
      end
      tick();
      @(negedge r_clk);
      cyc++;
    end
    n_checks++; if (pops !== 16) $display("FAIL burst_pop_count: got %0d want 16", pops); else n_pass++;
    n_checks++; if (bubbles !== 0) $display("FAIL burst_bubbles: got %0d want 0", bubbles); else n_pass++;
    n_checks++; if (lvl_bad !== 0) $display("FAIL burst_level_aempty: got %0d bad cycles want 0", lvl_bad); else n_pass++;
    n_checks++; if (r_empty !== 1'b1) $display("FAIL burst_final_empty: got %b want 1", r_empty); else n_pass++;
    n_checks++; if (r_aempty !== 1'b1) $display("FAIL burst_final_aempty: got %b want 1", r_aempty); else n_pass++;
    n_checks++; if (rptr !== 5'b11000) $display("FAIL burst_final_rptr: got %b want 11000", rptr); else n_pass++;
    n_checks++; if (bus.dout_valid !== 1'b0) $display("FAIL burst_final_valid: got %b want 0", bus.dout_valid); else n_pass++;
  endtask

  task automatic test_backpressure();
    int ren_cnt, pops;
    logic stable;
    do_reset();
    tick();
    repeat (3) write_word();
    ren_cnt = 0; stable = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      @(negedge r_clk);
      if (bus.ren) ren_cnt++;
      if (k >= 6 && !(bus.dout_valid === 1'b1 && bus.dout === exp_q[0])) stable = 1'b0;
    end
    n_checks++; if (ren_cnt !== 2) $display("FAIL bp_ren_count: got %0d want 2", ren_cnt); else n_pass++;
    n_checks++; if (r_level !== 5'd1) $display("FAIL bp_level: got %0d want 1", r_level); else n_pass++;
    n_checks++; if (r_aempty !== 1'b1) $display("FAIL bp_aempty: got %b want 1", r_aempty); else n_pass++;
    n_checks++; if (stable !== 1'b1) $display("FAIL bp_head_stable: got %b want 1", stable); else n_pass++;
    tick();
    bus.dout_ready = 1'b1;
    pops = 0;
    for (int k = 0; k < 20 && pops < 3; k++) begin
      @(negedge r_clk);
      if (bus.ren) ren_cnt++;
      if (bus.dout_valid) begin
        n_checks++;
        if (bus.dout !== exp_q[0]) $display("FAIL bp_data[%0d]: got %h want %h", pops, bus.dout, exp_q[0]);
        else n_pass++;
        void'(exp_q.pop_front());
        pops++;
      end
      tick();
    end
    @(negedge r_clk);
    n_checks++; if (pops !== 3) $display("FAIL bp_pop_count: got %0d want 3", pops); else n_pass++;
    n_checks++; if (ren_cnt !== 3) $display("FAIL bp_total_ren: got %0d want 3", ren_cnt); else n_pass++;
    n_checks++; if (r_empty !== 1'b1) $display("FAIL bp_final_empty: got %b want 1", r_empty); else n_pass++;
    bus.dout_ready = 1'b0;
  endtask

  task automatic test_wrap();
    int written, pops, cyc, gray_bad, empty_bad;
    logic rbin_wrap, raddr_wrap;
    logic [3:0] last_raddr;
    logic [4:0] prev_rptr, space;
    do_reset();
    written = 0; pops = 0; cyc = 0; gray_bad = 0; empty_bad = 0;
    rbin_wrap = 1'b0; raddr_wrap = 1'b0; last_raddr = 4'd0; prev_rptr = rptr;
    tick();
    while (pops < 40 && cyc < 2000) begin
      space = wbin - g2b(rptr);
      if (written < 40 && space < 5'd16) begin
        write_word();
        written++;
      end
      bus.dout_ready = 1'($urandom_range(0, 1));
      @(negedge r_clk);
      if (rptr !== prev_rptr) begin
        if ($countones(rptr ^ prev_rptr) != 1) gray_bad++;
        if (g2b(prev_rptr) == 5'd31 && g2b(rptr) == 5'd0) rbin_wrap = 1'b1;
        prev_rptr = rptr;
      end
      if (bus.ren) begin
        if (bus.raddr == 4'd0 && last_raddr == 4'd15) raddr_wrap = 1'b1;
        last_raddr = bus.raddr;
      end
      if (r_empty !== (rptr == w_h2)) empty_bad++;
      if (bus.dout_valid && bus.dout_ready) begin
        n_checks++;
        if (bus.dout !== exp_q[0]) $display("FAIL wrap_data[%0d]: got %h want %h", pops, bus.dout, exp_q[0]);
        else n_pass++;
        void'(exp_q.pop_front());
        pops++;
      end
      tick();
      cyc++;
    end
    n_checks++; if (pops !== 40) $display("FAIL wrap_pop_count: got %0d want 40", pops); else n_pass++;
    n_checks++; if (gray_bad !== 0) $display("FAIL wrap_gray_step: got %0d multi-bit steps want 0", gray_bad); else n_pass++;
    n_checks++; if (rbin_wrap !== 1'b1) $display("FAIL wrap_rbin: got %b want 1", rbin_wrap); else n_pass++;
    n_checks++; if (raddr_wrap !== 1'b1) $display("FAIL wrap_raddr: got %b want 1", raddr_wrap); else n_pass++;
    n_checks++; if (empty_bad !== 0) $display("FAIL wrap_empty_match: got %0d bad cycles want 0", empty_bad); else n_pass++;
    bus.dout_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int bad;
    do_reset();
    tick();
    repeat (8) write_word();
    repeat (8) tick();
    bus.dout_ready = 1'b1;
    #1;
    n_checks++; if (bus.ren !== 1'b1) $display("FAIL mid_ren_before: got %b want 1", bus.ren); else n_pass++;
    n_checks++; if (bus.dout_valid !== 1'b1) $display("FAIL mid_valid_before: got %b want 1", bus.dout_valid); else n_pass++;
    r_rstn = 1'b0;
    #1;
    n_checks++; if (r_empty !== 1'b1) $display("FAIL mid_empty: got %b want 1", r_empty); else n_pass++;
    n_checks++; if (r_aempty !== 1'b1) $display("FAIL mid_aempty: got %b want 1", r_aempty); else n_pass++;
    n_checks++; if (bus.dout_valid !== 1'b0) $display("FAIL mid_valid: got %b want 0", bus.dout_valid); else n_pass++;
    n_checks++; if (bus.dout !== 8'd0) $display("FAIL mid_dout: got %h want 0", bus.dout); else n_pass++;
    n_checks++; if (bus.ren !== 1'b0) $display("FAIL mid_ren: got %b want 0", bus.ren); else n_pass++;
    n_checks++; if (bus.raddr !== 4'd0) $display("FAIL mid_raddr: got %0d want 0", bus.raddr); else n_pass++;
    n_checks++; if (r_level !== 5'd0) $display("FAIL mid_level: got %0d want 0", r_level); else n_pass++;
    n_checks++; if (rptr !== 5'd0) $display("FAIL mid_rptr: got %b want 0", rptr); else n_pass++;
    wptr = '0;
    wbin = '0;
    exp_q.delete();
    bus.dout_ready = 1'b0;
    repeat (2) @(posedge r_clk);
    #1;
    r_rstn = 1'b1;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge r_clk);
      if (bus.ren !== 1'b0 || bus.dout_valid !== 1'b0) bad++;
      tick();
    end
    n_checks++; if (bad !== 0) $display("FAIL mid_after_release: got %0d active cycles want 0", bad); else n_pass++;
  endtask

  initial begin
    r_rstn = 1'b0;
    wptr = '0;
    wbin = '0;
    bus.dout_ready = 1'b0;
    n_checks = 0;
    n_pass = 0;
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
